// File: rtl/fft_bf_stage.sv
// Radix-2 DIF butterfly stage: buffers D blocks of A samples, pairs them with
// the following D blocks of B samples and emits A+B / A-B with optional scaling.
module fft_bf_stage #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = 10,
    parameter int NUM       = 16,
    parameter int DATA      = 512,
    parameter int DIST      = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM*IN_WIDTH-1:0]  din_i,
    input  logic [NUM*IN_WIDTH-1:0]  din_q,
    input  logic                     valid_in,
    input  logic                     scale_en,
    input  logic                     clr,
    output logic [NUM*OUT_WIDTH-1:0] do1_re,
    output logic [NUM*OUT_WIDTH-1:0] do1_im,
    output logic [NUM*OUT_WIDTH-1:0] do2_re,
    output logic [NUM*OUT_WIDTH-1:0] do2_im,
    output logic                     valid_out,
    output logic                     frame_last,
    output logic                     ovf
);

    localparam int D      = DIST / NUM;
    localparam int NBLK   = DATA / NUM;
    localparam int BLK_W  = $clog2(NBLK);
    localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
    localparam int BUF_W  = 2 * NUM * IN_WIDTH;
    // Wide enough for A-B plus the rounding increment, and for the saturation compare.
    localparam int WX     = (IN_WIDTH + 2 > OUT_WIDTH + 1) ? IN_WIDTH + 2 : OUT_WIDTH + 1;

    localparam logic [BLK_W-1:0]      LAST_BLK = BLK_W'(NBLK - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(D - 1);
    localparam logic signed [WX-1:0]  ONE      = WX'(1);
    localparam logic signed [WX-1:0]  MAX_V    = WX'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WX-1:0]  MIN_V    = ~MAX_V;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    state_t             state;
    logic [BLK_W-1:0]   blk;
    logic [IDX_W-1:0]   idx;
    logic               scale_q;
    logic               accept;

    logic [BUF_W-1:0]   mem [D];
    logic [BUF_W-1:0]   a_blk;

    logic [NUM*OUT_WIDTH-1:0] s_re, s_im, d_re, d_im;
    logic                     sat_any;

    assign accept = valid_in & ~clr;
    assign a_blk  = mem[idx];

    // NOTE: the block buffer has no reset; every slot is written in FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (accept && state == FILL) begin
            mem[idx] <= {din_q, din_i};
        end
    end

    function automatic logic [OUT_WIDTH-1:0] adapt(
        input  logic signed [WX-1:0] x,
        input  logic                 sc,
        output logic                 sat
    );
        logic signed [WX-1:0] y;
        y   = sc ? ((x + ONE) >>> 1) : x;
        sat = 1'b0;
        if (y > MAX_V) begin
            sat   = 1'b1;
            adapt = MAX_V[OUT_WIDTH-1:0];
        end else if (y < MIN_V) begin
            sat   = 1'b1;
            adapt = MIN_V[OUT_WIDTH-1:0];
        end else begin
            adapt = y[OUT_WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [WX-1:0] lane_ext(input logic [IN_WIDTH-1:0] v);
        lane_ext = WX'($signed(v));
    endfunction

    always_comb begin
        logic signed [WX-1:0] ar, ai, br, bi;
        logic                 o1, o2, o3, o4;
        s_re    = '0;
        s_im    = '0;
        d_re    = '0;
        d_im    = '0;
        sat_any = 1'b0;
        for (int j = 0; j < NUM; j++) begin
            ar = lane_ext(a_blk[j*IN_WIDTH +: IN_WIDTH]);
            ai = lane_ext(a_blk[NUM*IN_WIDTH + j*IN_WIDTH +: IN_WIDTH]);
            br = lane_ext(din_i[j*IN_WIDTH +: IN_WIDTH]);
            bi = lane_ext(din_q[j*IN_WIDTH +: IN_WIDTH]);
            s_re[j*OUT_WIDTH +: OUT_WIDTH] = adapt(ar + br, scale_q, o1);
            s_im[j*OUT_WIDTH +: OUT_WIDTH] = adapt(ai + bi, scale_q, o2);
            d_re[j*OUT_WIDTH +: OUT_WIDTH] = adapt(ar - br, scale_q, o3);
            d_im[j*OUT_WIDTH +: OUT_WIDTH] = adapt(ai - bi, scale_q, o4);
            sat_any = sat_any | o1 | o2 | o3 | o4;
        end
    end

    // NOTE: all state and output registers use non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FILL;
            blk        <= '0;
            idx        <= '0;
            scale_q    <= 1'b0;
            do1_re     <= '0;
            do1_im     <= '0;
            do2_re     <= '0;
            do2_im     <= '0;
            valid_out  <= 1'b0;
            frame_last <= 1'b0;
            ovf        <= 1'b0;
        end else if (clr) begin
            state      <= FILL;
            blk        <= '0;
            idx        <= '0;
            valid_out  <= 1'b0;
            frame_last <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_last <= 1'b0;
            ovf        <= 1'b0;
            if (valid_in) begin
                blk <= (blk == LAST_BLK) ? '0 : blk + BLK_W'(1);
                if (blk == '0) begin
                    scale_q <= scale_en;
                end
                if (idx == LAST_IDX) begin
                    idx   <= '0;
                    state <= (state == FILL) ? PAIR : FILL;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
                if (state == PAIR) begin
                    do1_re     <= s_re;
                    do1_im     <= s_im;
                    do2_re     <= d_re;
                    do2_im     <= d_im;
                    valid_out  <= 1'b1;
                    frame_last <= (blk == LAST_BLK);
                    ovf        <= sat_any;
                end
            end
        end
    end

endmodule

// File: doc/fft_bf_stage.md
# fft_bf_stage

Parametrised radix-2 DIF butterfly stage for the streaming FFT datapath. Accepts NUM complex samples per valid cycle and pairs sample k with sample k+DIST, where DIST can span many input cycles, using an internal block buffer. It emits sum and difference lanes with optional 1-bit scaling, rounding and saturation. Multiple instances are chained, with a different DIST each, to build the full DATA-point transform.

## Interface
- IN_WIDTH, 9: signed input sample width (I and Q).
- OUT_WIDTH, 10: signed output width, ≥ IN_WIDTH−1.
- NUM, 16: lanes per cycle, power of two.
- DATA, 512: samples per frame, multiple of 2·DIST.
- DIST, 256: pair distance in samples; multiple of NUM, NUM ≤ DIST ≤ DATA/2. D = DIST/NUM is the buffer depth in blocks.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- din_i  in  NUM×IN_WIDTH signed  real lanes.
- din_q  in  NUM×IN_WIDTH signed  imaginary lanes.
- valid_in  in  1  input block valid; accepted on every rising edge where it is 1.
- scale_en  in  1  enables divide-by-2 with rounding; sampled at frame start.
- clr  in  1  synchronous clear of counters and state; has priority over valid_in.
- do1_re, do1_im  out  NUM×OUT_WIDTH signed  A+B lanes.
- do2_re, do2_im  out  NUM×OUT_WIDTH signed  A−B lanes.
- valid_out  out  1  output valid.
- frame_last  out  1  pulse with the last output block of a frame.
- ovf  out  1  pulse when any lane of the current output saturated.

## Operation
- Block counter blk (0..DATA/NUM−1) advances only on accepted blocks and wraps to 0 after the last block.
- Position in group: pos = blk mod 2D. Slot index: idx = pos mod D.
- State machine, two states:
  - FILL (pos < D): the accepted block is written to buf[idx]. No output is produced.
  - PAIR (pos ≥ D): the accepted block is B. It is paired lane-for-lane with A = buf[idx].
  - FILL→PAIR after D accepts. PAIR→FILL after D accepts.
- Reset state is FILL, blk = 0.
- Lane arithmetic, full precision IN_WIDTH+1 bits:
  - s = A + B.
  - d = A − B.
  - Applied to re and im separately.
- Scaling when the frame's latched scale_en = 1: x' = (x + 1) >>> 1 (arithmetic shift, round half up).
- Width adaptation:
  - If the result fits OUT_WIDTH: sign-extend.
  - Otherwise: saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] and set ovf for that output cycle.
- scale_en is latched on the accept of blk = 0. It is held for the whole frame.
- Buffer contents are not cleared by reset or clr. FILL always overwrites a slot before PAIR reads it.
- clr:
  - Forces FILL, blk = 0.
  - Drives valid_out, frame_last and ovf low next cycle.
  - A block presented in the clr cycle is discarded.

## Timing
- Reset values: all do* = 0, valid_out = 0, frame_last = 0, ovf = 0, latched scale = 0.
- Outputs are registered. A PAIR block accepted at edge t drives valid_out = 1 with data during cycle t..t+1, i.e. latency 1.
- valid_out is 1 for exactly one cycle per PAIR accept. Otherwise it is 0 and do* hold their last value.
- Gaps in valid_in are allowed anywhere. Results are independent of gap placement.
- There is no backpressure. The downstream stage must accept every valid_out.
- frame_last = 1 together with the valid_out of blk = DATA/NUM−1.
- Asynchronous reset mid-frame aborts immediately. The next accepted block is blk 0, in FILL.

## Test plan
- Reset check: hold rstn = 0 for 3 cycles with valid_in = 1 and random data. Required: all outputs 0 throughout; first accepted block after release is blk 0.
- Basic pairing (defaults), A blocks re = 1, im = −3, B blocks re = 2, im = 5, 32 back-to-back blocks:
  - do1 = (3, 2), do2 = (−1, −8) on all lanes.
  - valid_out first rises one cycle after the 17th accept.
  - 16 valid_out cycles total.
  - frame_last on the 16th valid_out cycle.
- Saturation, OUT_WIDTH = 9 instance:
  - A = 255, B = 255 → do1 = 255, ovf = 1.
  - A = −256, B = 255 → do2 = −256, ovf = 1.
  - A = 3, B = 4 → ovf = 0.
- Scaling, scale_en = 1 at blk 0:
  - A = 255, B = 254 → do1 = 255, do2 = 1.
  - A = −3, B = 0 → do1 = −1.
  - Toggling scale_en mid-frame has no effect until the next frame.
- Gapped input: ramp data, din_i lane j = (blk·NUM + j) mod 256, with random 0–3 cycle gaps in valid_in. Required: output sequence identical to the gapless run; valid_out count = DATA/(2·NUM) per frame.
- Mid-frame abort:
  - Assert clr after 5 FILL blocks, then send a full frame. Output must match a clean frame.
  - Repeat with rstn pulsed low during PAIR. Output must match as well.
